// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset/lock sequencer.
// Holds the FSM state encoding, the relock counter width and a max helper.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLLRST = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STABLE = 2'd2,
    ST_RUN    = 2'd3
  } pll_state_e;

  localparam int RELOCK_CNT_W = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchroniser with synchronous active-high reset.
// Ports: clk, rst, d (async input), q (synchronised output).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_seq.sv
// PLL reset/lock sequencer: pulses PLL_RST, qualifies LOCK, gates datapath.
// Ports: CLKI, RST (sync, active high), PLL_LOCK (async), REQ_RESEQ in;
//   PLL_RST, SYS_RST, READY, RELOCK_CNT[7:0], STATE[1:0] out.
// Optional: define PLL_LOCK_TIMEOUT_EN to re-pulse the PLL after
//   LOCK_TIMEOUT_CYC cycles in WAIT without lock.
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int STABLE_CYC       = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536
) (
  input  logic                    CLKI,
  input  logic                    RST,
  input  logic                    PLL_LOCK,
  input  logic                    REQ_RESEQ,
  output logic                    PLL_RST,
  output logic                    SYS_RST,
  output logic                    READY,
  output logic [RELOCK_CNT_W-1:0] RELOCK_CNT,
  output logic [1:0]              STATE
);

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int CNT_MAX =
    max2(max2(RST_PULSE_CYC, STABLE_CYC), LOCK_TIMEOUT_CYC);
`else
  // Timeout disabled: the term is zeroed so it cannot widen cnt.
  localparam int CNT_MAX =
    max2(RST_PULSE_CYC, STABLE_CYC) + 0 * LOCK_TIMEOUT_CYC;
`endif

  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYC - 1);
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
`endif

  logic                    lock_s;
  pll_state_e              state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [RELOCK_CNT_W-1:0] relock_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (CLKI),
    .rst (RST),
    .d   (PLL_LOCK),
    .q   (lock_s)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt + 1'b1;
    relock_d = RELOCK_CNT;
    unique case (state)
      ST_PLLRST: begin
        if (cnt == RST_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
`ifdef PLL_LOCK_TIMEOUT_EN
        if (REQ_RESEQ)           state_d = ST_PLLRST;
        else if (lock_s)         state_d = ST_STABLE;
        else if (cnt == TO_LAST) state_d = ST_PLLRST;
`else
        // Unbounded wait: hold cnt so it never wraps.
        cnt_d = cnt;
        if (REQ_RESEQ)   state_d = ST_PLLRST;
        else if (lock_s) state_d = ST_STABLE;
`endif
      end
      ST_STABLE: begin
        if (REQ_RESEQ)            state_d = ST_PLLRST;
        else if (!lock_s)         state_d = ST_WAIT;
        else if (cnt == STB_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt;
        // Lock loss wins over a coincident request so it is still counted.
        if (!lock_s) begin
          state_d = ST_PLLRST;
          if (RELOCK_CNT != '1) relock_d = RELOCK_CNT + 1'b1;
        end else if (REQ_RESEQ) begin
          state_d = ST_PLLRST;
        end
      end
      default: state_d = ST_PLLRST;
    endcase
    if (state_d != state) cnt_d = '0;
  end

  always_ff @(posedge CLKI) begin
    if (RST) begin
      state      <= ST_PLLRST;
      cnt        <= '0;
      RELOCK_CNT <= '0;
      PLL_RST    <= 1'b1;
      SYS_RST    <= 1'b1;
      READY      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      RELOCK_CNT <= relock_d;
      PLL_RST    <= (state_d == ST_PLLRST);
      SYS_RST    <= (state_d != ST_RUN);
      READY      <= (state_d == ST_RUN);
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq: scoreboard against a phase model.
// Works with or without PLL_LOCK_TIMEOUT_EN defined.
module tb_pll_lock_seq;

  localparam int RP = 4;
  localparam int SC = 8;
  localparam int TO = 32;

  localparam int P_RST = 0;
  localparam int P_WAIT = 1;
  localparam int P_STB = 2;
  localparam int P_RUN = 3;

  logic       CLKI = 1'b0;
  logic       RST = 1'b1;
  logic       PLL_LOCK = 1'b0;
  logic       REQ_RESEQ = 1'b0;
  logic       PLL_RST;
  logic       SYS_RST;
  logic       READY;
  logic [7:0] RELOCK_CNT;
  logic [1:0] STATE;

  pll_lock_seq #(
    .RST_PULSE_CYC    (RP),
    .STABLE_CYC       (SC),
    .LOCK_TIMEOUT_CYC (TO)
  ) dut (
    .CLKI       (CLKI),
    .RST        (RST),
    .PLL_LOCK   (PLL_LOCK),
    .REQ_RESEQ  (REQ_RESEQ),
    .PLL_RST    (PLL_RST),
    .SYS_RST    (SYS_RST),
    .READY      (READY),
    .RELOCK_CNT (RELOCK_CNT),
    .STATE      (STATE)
  );

  always #5 CLKI = ~CLKI;

  typedef struct {
    logic [1:0] st;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] rc;
  } exp_t;

  exp_t sbq[$];

  int n_chk = 0;
  int n_fail = 0;

  // Phase model: phase, edges spent in phase, lock history, relock tally.
  int   m_ph = P_RST;
  int   m_age = 0;
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  int   m_rc = 0;

  task automatic model_edge(input logic r, input logic lk, input logic rq);
    logic ls;
    int   nxt;
    if (r) begin
      m_ph = P_RST;
      m_age = 0;
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      m_rc = 0;
    end else begin
      ls = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      nxt = m_ph;
      m_age++;
      case (m_ph)
        P_RST: if (m_age == RP) nxt = P_WAIT;
        P_WAIT: begin
          if (rq) nxt = P_RST;
          else if (ls) nxt = P_STB;
`ifdef PLL_LOCK_TIMEOUT_EN
          else if (m_age == TO) nxt = P_RST;
`endif
        end
        P_STB: begin
          if (rq) nxt = P_RST;
          else if (!ls) nxt = P_WAIT;
          else if (m_age == SC) nxt = P_RUN;
        end
        default: begin
          if (!ls) begin
            nxt = P_RST;
            if (m_rc < 255) m_rc++;
          end else if (rq) begin
            nxt = P_RST;
          end
        end
      endcase
      if (nxt != m_ph) m_age = 0;
      m_ph = nxt;
    end
  endtask

  task automatic drive(input logic lk, input logic rq);
    exp_t e;
    PLL_LOCK = lk;
    REQ_RESEQ = rq;
    @(posedge CLKI);
    #1;
    model_edge(RST, lk, rq);
    e.st = 2'(m_ph);
    e.pll_rst = (m_ph == P_RST);
    e.sys_rst = (m_ph != P_RUN);
    e.ready = (m_ph == P_RUN);
    e.rc = 8'(m_rc);
    sbq.push_back(e);
  endtask

  task automatic wait_phase(input int tgt, input logic lk, input int maxc);
    int k = 0;
    while (m_ph != tgt && k < maxc) begin
      drive(lk, 1'b0);
      k++;
    end
    n_chk++;
    if (m_ph != tgt) begin
      n_fail++;
      $display("FAIL wait_phase got phase %0d need %0d", m_ph, tgt);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLKI);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_chk++;
        if (STATE !== e.st || PLL_RST !== e.pll_rst ||
            SYS_RST !== e.sys_rst || READY !== e.ready ||
            RELOCK_CNT !== e.rc) begin
          n_fail++;
          $display("FAIL outputs t=%0t got st=%0d pr=%b sr=%b rdy=%b rc=%0d need st=%0d pr=%b sr=%b rdy=%b rc=%0d",
                   $time, STATE, PLL_RST, SYS_RST, READY, RELOCK_CNT,
                   e.st, e.pll_rst, e.sys_rst, e.ready, e.rc);
        end
      end
    end
  end

  initial begin
    logic lk;
    logic rq;

    RST = 1'b1;
    repeat (3) drive(1'b0, 1'b0);
    RST = 1'b0;

    // Lock tied high from reset release.
    wait_phase(P_RUN, 1'b1, 40);
    repeat (3) drive(1'b1, 1'b0);

    // Re-sequence, then glitch lock low for 2 cycles mid-STABLE.
    drive(1'b1, 1'b1);
    wait_phase(P_STB, 1'b1, 40);
    while (m_ph == P_STB && m_age < 5) drive(1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0);
    wait_phase(P_RUN, 1'b1, 40);

    // Request in RUN, then requests during PLLRST.
    drive(1'b1, 1'b1);
    repeat (2) drive(1'b1, 1'b1);
    wait_phase(P_RUN, 1'b1, 40);

    // Request coincident with synchronised lock loss.
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    wait_phase(P_RUN, 1'b1, 40);

    // Repeated lock losses saturate the relock counter.
    for (int i = 0; i < 300; i++) begin
      repeat (3) drive(1'b0, 1'b0);
      wait_phase(P_RUN, 1'b1, 40);
    end
    n_chk++;
    if (RELOCK_CNT !== 8'd255) begin
      n_fail++;
      $display("FAIL relock_sat got %0d need 255", RELOCK_CNT);
    end

    // Mid-operation reset clears everything.
    RST = 1'b1;
    drive(1'b1, 1'b0);
    RST = 1'b0;

    // Lock never arrives.
    repeat (120) drive(1'b0, 1'b0);

    // Random lock, request and reset activity.
    lk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) lk = ~lk;
      rq = ($urandom_range(0, 39) == 0);
      RST = ($urandom_range(0, 599) == 0);
      drive(lk, rq);
    end
    RST = 1'b0;
    drive(1'b1, 1'b0);

    repeat (2) @(negedge CLKI);
    #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d left need 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
